// File: rtl/cfg_table_writer_if.sv
// cfg_table_writer_if: configuration beat stream into the loader and table RAM write port out of it
//   s_data/s_valid/s_last/s_ready : configuration stream (valid/ready handshake)
//   addra/dina/ena/wea            : RAM port-A write side
//   err/wr_count                  : malformed-message pulse and written-entry counter
interface cfg_table_writer_if #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 193,
  parameter int IN_BITS   = 32
);
  logic [IN_BITS-1:0]   s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;
  logic [ADDR_BITS-1:0] addra;
  logic [DATA_BITS-1:0] dina;
  logic                 ena;
  logic                 wea;
  logic                 err;
  logic [15:0]          wr_count;
  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, addra, dina, ena, wea, err, wr_count
  );
  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, addra, dina, ena, wea, err, wr_count
  );
endinterface

// File: rtl/cfg_table_writer.sv
// cfg_table_writer: assembles a header beat plus NBEATS data beats into one table RAM write
//   clk     : sole clock, shared with the RAM write port
//   aresetn : asynchronous active-low reset
//   b       : slave side of cfg_table_writer_if (stream in, RAM write port / err / wr_count out)
module cfg_table_writer #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 193,
  parameter int IN_BITS   = 32
) (
  input logic            clk,
  input logic            aresetn,
  cfg_table_writer_if.slave b
);
  localparam int NBEATS = (DATA_BITS + IN_BITS - 1) / IN_BITS;
  localparam int CW     = NBEATS > 1 ? $clog2(NBEATS) : 1;
  typedef enum logic [1:0] {IDLE, DATA, WRITE, DROP} state_t;
  state_t               state, nxt;
  logic [CW-1:0]        cnt, cnt_n;
  logic [ADDR_BITS-1:0] addr_q, addr_n;
  logic [DATA_BITS-1:0] asm_q, asm_n;
  logic                 err_n, hs, last_beat;
  assign hs        = b.s_valid && b.s_ready;
  assign last_beat = cnt == CW'(NBEATS - 1);
  assign b.wea     = b.ena;
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt    = state;
    cnt_n  = cnt;
    addr_n = addr_q;
    asm_n  = asm_q;
    err_n  = 1'b0;
    case (state)
      IDLE: if (hs) begin
        addr_n = b.s_data[ADDR_BITS-1:0];
        cnt_n  = '0;
        err_n  = b.s_last;
        nxt    = b.s_last ? IDLE : DATA;
      end
      DATA: if (hs) begin
        // beat cnt lands at [cnt*IN_BITS +: IN_BITS]; bits past DATA_BITS simply have no target
        for (int i = 0; i < DATA_BITS; i++)
          if (CW'(i / IN_BITS) == cnt) asm_n[i] = b.s_data[i % IN_BITS];
        cnt_n = cnt + 1'b1;
        err_n = b.s_last != last_beat;
        nxt   = last_beat ? (b.s_last ? WRITE : DROP) : (b.s_last ? IDLE : DATA);
      end
      WRITE: nxt = IDLE;
      DROP:  if (hs && b.s_last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      cnt        <= '0;
      addr_q     <= '0;
      asm_q      <= '0;
      b.s_ready  <= 1'b0;
      b.ena      <= 1'b0;
      b.err      <= 1'b0;
      b.addra    <= '0;
      b.dina     <= '0;
      b.wr_count <= '0;
    end else begin
      cnt       <= cnt_n;
      addr_q    <= addr_n;
      asm_q     <= asm_n;
      b.err     <= err_n;
      b.s_ready <= nxt != WRITE;
      b.ena     <= nxt == WRITE;
      // addra/dina are loaded only on a write so they hold between writes
      if (nxt == WRITE) begin
        b.addra    <= addr_n;
        b.dina     <= asm_n;
        b.wr_count <= b.wr_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_cfg_table_writer.sv
// tb_cfg_table_writer: randomized stimulus checked every cycle against a message-level model
module tb_cfg_table_writer;
  localparam int AB = 5, DB = 193, IB = 32, NB = 7;
  logic clk = 0, aresetn = 1;
  cfg_table_writer_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .IN_BITS(IB)) bus();
  cfg_table_writer #(.ADDR_BITS(AB), .DATA_BITS(DB), .IN_BITS(IB)) dut (
    .clk(clk), .aresetn(aresetn), .b(bus)
  );
  always #5 clk = ~clk;
  logic          exp_ready = 0, exp_ena = 0, exp_err = 0;
  logic [15:0]   exp_cnt = 0;
  logic [AB-1:0] exp_addra = '0;
  logic [DB-1:0] exp_dina = '0;
  logic [IB-1:0] msg[$];
  bit            dropping = 0;
  int            vectors = 0, miscompares = 0;
  bit            chk = 0;
  int            n_wr = 0, n_err = 0, w0, e0, s0;
  longint        cyc = 0;
  longint        wr_cyc[$];
  logic [AB-1:0] last_addr = '0;
  logic [DB-1:0] last_data = '0, ref_data;
  logic [IB-1:0] dat[16];
  // Model: collect the accepted beats of a message, judge it when it ends or overruns.
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      exp_ready = 0; exp_ena = 0; exp_err = 0; exp_cnt = 0;
      exp_addra = '0; exp_dina = '0; msg.delete(); dropping = 0;
    end else begin
      exp_err = 0;
      exp_ena = 0;
      if (bus.s_valid && exp_ready) begin
        if (dropping) dropping = !bus.s_last;
        else begin
          msg.push_back(bus.s_data);
          if (msg.size() == 1 && bus.s_last) begin
            exp_err = 1; msg.delete();
          end else if (msg.size() == NB + 1 && bus.s_last) begin
            exp_ena = 1;
            exp_addra = msg[0][AB-1:0];
            for (int i = 0; i < DB; i++) exp_dina[i] = msg[1 + i / IB][i % IB];
            exp_cnt = exp_cnt + 16'd1;
            msg.delete();
          end else if (msg.size() == NB + 1) begin
            exp_err = 1; dropping = 1; msg.delete();
          end else if (bus.s_last) begin
            exp_err = 1; msg.delete();
          end
        end
      end
      exp_ready = !exp_ena;
    end
  end
  task automatic cmp(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (chk) begin
    cyc++;
    vectors++;
    cmp("s_ready", bus.s_ready, exp_ready);
    cmp("ena", bus.ena, exp_ena);
    cmp("wea", bus.wea, exp_ena);
    cmp("err", bus.err, exp_err);
    cmp("wr_count", bus.wr_count, exp_cnt);
    cmp("addra", bus.addra, exp_addra);
    cmp("dina", bus.dina, exp_dina);
    if (bus.ena === 1'b1) begin
      n_wr++; wr_cyc.push_back(cyc); last_addr = bus.addra; last_data = bus.dina;
    end
    if (bus.err === 1'b1) n_err++;
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic beat(input logic [IB-1:0] d, input bit l, input bit gaps);
    int t;
    bit ok;
    t = 0;
    ok = 0;
    if (gaps) begin
      bus.s_valid = 0;
      bus.s_data = $urandom;
      repeat ($urandom_range(0, 2)) tick();
    end
    bus.s_data = d;
    bus.s_last = l;
    bus.s_valid = 1;
    while (!ok) begin
      @(negedge clk);
      ok = bus.s_ready;
      tick();
      if (!ok && ++t > 50) begin
        miscompares++;
        $display("FAIL handshake_timeout got no s_ready want s_ready within 50 cycles");
        break;
      end
    end
  endtask
  task automatic idle(input int n);
    bus.s_valid = 0;
    bus.s_last = 0;
    repeat (n) tick();
  endtask
  task automatic send(input logic [IB-1:0] hdr, input int nd, input bit gaps);
    beat(hdr, nd == 0, gaps);
    for (int i = 0; i < nd; i++) beat(dat[i], i == nd - 1, gaps);
  endtask
  task automatic rand_dat();
    for (int i = 0; i < 16; i++) dat[i] = $urandom;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200us");
    $fatal(1);
  end
  initial begin
    bus.s_valid = 0; bus.s_last = 0; bus.s_data = '0;
    #1 aresetn = 0;
    chk = 1;
    #1;
    cmp("rst_ready", bus.s_ready, 1'b0);
    cmp("rst_ena", bus.ena, 1'b0);
    cmp("rst_dina", bus.dina, '0);
    repeat (3) tick();
    aresetn = 1;
    tick();
    // basic write
    for (int i = 0; i < NB; i++) dat[i] = 32'h11111111 * (i + 1);
    w0 = n_wr;
    send(32'h0000_0013, NB, 0);
    idle(2);
    cmp("basic_writes", 32'(n_wr - w0), 1);
    cmp("basic_addr", last_addr, 5'h13);
    cmp("basic_lo", last_data[31:0], 32'h11111111);
    cmp("basic_hi", last_data[191:160], 32'h66666666);
    cmp("basic_top", last_data[192], 1'b1);
    cmp("basic_count", bus.wr_count, 16'd1);
    ref_data = last_data;
    // back-to-back
    e0 = n_err; s0 = wr_cyc.size(); w0 = n_wr;
    rand_dat(); send(0, NB, 0);
    rand_dat(); send(1, NB, 0);
    rand_dat(); send(31, NB, 0);
    idle(2);
    cmp("b2b_writes", 32'(n_wr - w0), 3);
    if (wr_cyc.size() >= s0 + 3) begin
      cmp("b2b_gap1", 64'(wr_cyc[s0+1] - wr_cyc[s0]), 64'd9);
      cmp("b2b_gap2", 64'(wr_cyc[s0+2] - wr_cyc[s0+1]), 64'd9);
    end
    cmp("b2b_err", 32'(n_err - e0), 0);
    cmp("b2b_count", bus.wr_count, 16'd4);
    cmp("b2b_last_addr", last_addr, 5'd31);
    // early s_last on data beat 3, then a good message to address 2
    e0 = n_err; w0 = n_wr;
    rand_dat(); send(5, 3, 0);
    idle(1);
    cmp("early_err", 32'(n_err - e0), 1);
    cmp("early_nowrite", 32'(n_wr - w0), 0);
    rand_dat(); send(2, NB, 0);
    idle(2);
    cmp("early_next_write", 32'(n_wr - w0), 1);
    cmp("early_next_addr", last_addr, 5'd2);
    // missing s_last, two extra beats
    e0 = n_err; w0 = n_wr;
    rand_dat(); send(7, NB + 2, 0);
    idle(1);
    cmp("drop_err", 32'(n_err - e0), 1);
    cmp("drop_nowrite", 32'(n_wr - w0), 0);
    rand_dat(); send(8, NB, 0);
    idle(2);
    cmp("drop_next_addr", last_addr, 5'd8);
    // header-only message, then upper header bits ignored
    e0 = n_err; w0 = n_wr;
    send(32'hFFFF_FFE5, 0, 0);
    idle(1);
    cmp("hdr_err", 32'(n_err - e0), 1);
    cmp("hdr_nowrite", 32'(n_wr - w0), 0);
    rand_dat(); send(32'hFFFF_FFE5, NB, 0);
    idle(2);
    cmp("hdr_addr", last_addr, 5'h05);
    // reset after data beat 4
    w0 = n_wr;
    rand_dat();
    beat(32'h3, 0, 0);
    for (int i = 0; i < 4; i++) beat(dat[i], 0, 0);
    aresetn = 0;
    bus.s_valid = 0;
    #1;
    cmp("rst_mid_count", bus.wr_count, 16'd0);
    cmp("rst_mid_ready", bus.s_ready, 1'b0);
    cmp("rst_mid_addra", bus.addra, 5'd0);
    cmp("rst_mid_nowrite", 32'(n_wr - w0), 0);
    repeat (3) tick();
    aresetn = 1;
    tick();
    rand_dat(); send(9, NB, 0);
    idle(2);
    cmp("rst_after_count", bus.wr_count, 16'd1);
    cmp("rst_after_addr", last_addr, 5'd9);
    // gappy valid gives the same entry as the gap-free case
    for (int i = 0; i < NB; i++) dat[i] = 32'h11111111 * (i + 1);
    send(32'h13, NB, 1);
    idle(2);
    cmp("gaps_data", last_data, ref_data);
    // random mix of good and malformed messages
    repeat (40) begin
      int kind, nd;
      kind = $urandom_range(0, 9);
      nd = kind < 6 ? NB : kind == 6 ? 0 : kind == 7 ? $urandom_range(1, NB - 1) : $urandom_range(NB + 1, NB + 3);
      rand_dat();
      send($urandom, nd, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
